// File: rtl/led_breathe_pkg.sv
// Shared types and sizing helpers for the breathing LED driver.
// Included by led_breathe_pwm and pwm_gen.
package led_breathe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } breathe_state_t;

    // Largest duty code for a w-bit duty word.
    function automatic int duty_max(input int w);
        return (1 << w) - 1;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM core: prescaler, period counter, period-start pulse,
// glitch-free duty latch and registered output compare.
module pwm_gen
    import led_breathe_pkg::*;
#(
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 390
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable_in,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              led_out,
    output logic              period_start
);

    localparam int PRESCALE_W = cnt_w(PRESCALE);
    localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] prescaler;
    logic [DUTY_W-1:0]     pwm_cnt;
    logic [DUTY_W-1:0]     cmp_duty;
    logic [DUTY_W-1:0]     cmp_next;
    logic                  start;

    // The compare sees the freshly latched duty on the first count of a period.
    assign start    = (prescaler == '0) && (pwm_cnt == '0);
    assign cmp_next = start ? duty_in : cmp_duty;

    // Free-running prescaler and period counter; only reset stops them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Latch duty once per period and drive the pin one clk after the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_start <= 1'b0;
            cmp_duty     <= '0;
            led_out      <= 1'b0;
        end else begin
            period_start <= start;
            cmp_duty     <= cmp_next;
            led_out      <= enable_in && (pwm_cnt < cmp_next);
        end
    end

endmodule

// File: rtl/led_breathe_pwm.sv
// Breathing LED driver: ramp/hold FSM feeding a PWM core.
// Optional gamma map enabled by defining LED_BREATHE_GAMMA_EN.
module led_breathe_pwm
    import led_breathe_pkg::*;
#(
    parameter int DUTY_W     = 8,
    parameter int PRESCALE   = 390,
    parameter int HOLD_TICKS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              step_tick,
    output logic              led_out,
    output logic [DUTY_W-1:0] duty,
    output logic              period_start
);

    localparam logic [DUTY_W-1:0] MAX    = DUTY_W'(duty_max(DUTY_W));
    localparam logic [DUTY_W-1:0] MAX_M1 = MAX - 1'b1;
    localparam logic [DUTY_W-1:0] ONE    = DUTY_W'(1);
    localparam int HOLD_W = cnt_w(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
    localparam bit HOLD_EN = (HOLD_TICKS > 0);

    breathe_state_t    state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              enable_q;
    logic [DUTY_W-1:0] map_duty;

    // Ramp/hold sequencer; a low enable parks it and wins over any strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            duty     <= '0;
            hold_cnt <= '0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
            if (!enable) begin
                state    <= IDLE;
                duty     <= '0;
                hold_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        duty  <= '0;
                        state <= UP;
                    end
                    UP: if (step_tick) begin
                        if (duty >= MAX_M1) begin
                            duty     <= MAX;
                            hold_cnt <= '0;
                            state    <= HOLD_EN ? HOLD_HI : DOWN;
                        end else begin
                            duty <= duty + 1'b1;
                        end
                    end
                    HOLD_HI: if (step_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= DOWN;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    DOWN: if (step_tick) begin
                        if (duty <= ONE) begin
                            duty     <= '0;
                            hold_cnt <= '0;
                            state    <= HOLD_EN ? HOLD_LO : UP;
                        end else begin
                            duty <= duty - 1'b1;
                        end
                    end
                    HOLD_LO: if (step_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= UP;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*DUTY_W-1:0] duty_sq;
    logic [DUTY_W-1:0]   gamma_q;

    assign duty_sq = duty * duty;

    // Squared-duty map, registered to keep the multiplier off the latch path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gamma_q <= '0;
        end else begin
            gamma_q <= DUTY_W'(duty_sq >> DUTY_W);
        end
    end

    assign map_duty = gamma_q;
`else
    assign map_duty = duty;
`endif

    pwm_gen #(
        .DUTY_W   (DUTY_W),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable_in    (enable_q),
        .duty_in      (map_duty),
        .led_out      (led_out),
        .period_start (period_start)
    );

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Bench for led_breathe_pwm: two instances (dwell 2 and dwell 0)
// driven in lockstep and compared against an arithmetic reference.
module tb_led_breathe_pwm;

    localparam int W    = 4;
    localparam int P    = 2;
    localparam int MAXD = 15;
    localparam int PER  = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       step_tick = 1'b0;
    logic       led_a, ps_a, led_b, ps_b;
    logic [W-1:0] duty_a, duty_b;

    always #5 clk = ~clk;

    led_breathe_pwm #(.DUTY_W(W), .PRESCALE(P), .HOLD_TICKS(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .step_tick(step_tick), .led_out(led_a), .duty(duty_a),
        .period_start(ps_a)
    );

    led_breathe_pwm #(.DUTY_W(W), .PRESCALE(P), .HOLD_TICKS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .step_tick(step_tick), .led_out(led_b), .duty(duty_b),
        .period_start(ps_b)
    );

    int checks = 0;
    int errors = 0;

    // reference state
    int  e;
    bit  active;
    int  pos;
    int  m_duty[2];
    int  m_cmp[2];
    int  m_gam[2];
    bit  m_led[2];
    bit  m_ps;
    bit  m_enq;
    int  hi_cnt;
    int  prev_cmp;
    bit  win_ok;

    typedef struct {
        bit en;
        bit st;
        int da;
        int db;
        bit led0;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s t=%0t actual %0d required %0d",
                         name, $time, act, exp);
        end
    endtask

    // Duty after `p` accepted strobes for dwell `h`: the waveform is a
    // triangle with flat tops and bottoms of h strobes each.
    function automatic int ramp(input int p, input int h);
        int q;
        q = p % (2 * (MAXD + h));
        if (q <= MAXD) return q;
        if (q <= MAXD + h) return MAXD;
        if (q <= 2 * MAXD + h) return 2 * MAXD + h - q;
        return 0;
    endfunction

    task automatic model_reset();
        e = 0; active = 0; pos = 0;
        m_ps = 0; m_enq = 0;
        hi_cnt = 0; prev_cmp = 0; win_ok = 0;
        for (int k = 0; k < 2; k++) begin
            m_duty[k] = 0; m_cmp[k] = 0; m_gam[k] = 0; m_led[k] = 0;
        end
    endtask

    // One clock: drive at negedge, advance reference, compare next negedge.
    task automatic tick(input bit en, input bit st);
        int idx;
        bit enq_used;
        enable = en;
        step_tick = st;
        e++;
        idx = (e - 1) % PER;
        enq_used = m_enq;
        for (int k = 0; k < 2; k++) begin
            if (idx == 0) begin
`ifdef LED_BREATHE_GAMMA_EN
                m_cmp[k] = m_gam[k];
`else
                m_cmp[k] = m_duty[k];
`endif
            end
            m_led[k] = enq_used && ((idx / P) < m_cmp[k]);
            m_gam[k] = (m_duty[k] * m_duty[k]) >> W;
        end
        m_ps = (idx == 0);
        m_enq = en;
        if (!en) begin
            active = 0;
            pos = 0;
        end else if (!active) begin
            active = 1;
        end else if (st) begin
            pos++;
        end
        m_duty[0] = active ? ramp(pos, 2) : 0;
        m_duty[1] = active ? ramp(pos, 0) : 0;
        @(negedge clk);
        chk("duty_a", duty_a, m_duty[0]);
        chk("duty_b", duty_b, m_duty[1]);
        chk("led_a", led_a, m_led[0]);
        chk("led_b", led_b, m_led[1]);
        chk("pstart", ps_a, m_ps);
        if (m_ps) begin
            if (win_ok) chk("period_hi", hi_cnt, P * prev_cmp);
            hi_cnt = 0;
            prev_cmp = m_cmp[0];
            win_ok = 1;
        end
        if (!enq_used) win_ok = 0;
        hi_cnt += int'(led_a);
    endtask

    initial begin
        bit en;
        bit st;

        // directed table: ramp to 9, drop enable with a strobe, restart,
        // then run past the top where the two dwell settings diverge
        tbl.push_back('{1, 0, 0, 0, 0});
        for (int i = 1; i <= 9; i++) tbl.push_back('{1, 1, i, i, 0});
        tbl.push_back('{0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0});
        for (int i = 1; i <= 15; i++) tbl.push_back('{1, 1, i, i, 0});
        tbl.push_back('{1, 1, 15, 14, 0});
        tbl.push_back('{1, 1, 15, 13, 0});
        tbl.push_back('{1, 1, 14, 12, 0});

        // reset held with enable high
        reset_n = 1'b0;
        enable = 1'b1;
        step_tick = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_led", led_a, 0);
            chk("rst_duty", duty_a, 0);
            chk("rst_ps", ps_a, 0);
        end
        reset_n = 1'b1;
        model_reset();
        tick(1, 0);
        chk("first_ps", ps_a, 1);

        foreach (tbl[i]) begin
            tick(tbl[i].en, tbl[i].st);
            chk("tbl_duty_a", duty_a, tbl[i].da);
            chk("tbl_duty_b", duty_b, tbl[i].db);
            tick(tbl[i].en, 1'b0);
            if (tbl[i].led0) begin
                chk("drop_led_a", led_a, 0);
                chk("drop_led_b", led_b, 0);
            end
        end

        // asynchronous reset in the middle of a ramp
        #2 reset_n = 1'b0;
        #1;
        chk("arst_duty_a", duty_a, 0);
        chk("arst_duty_b", duty_b, 0);
        chk("arst_led", led_a, 0);
        chk("arst_ps", ps_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // full slow ramp, strobes not aligned to the PWM period
        tick(1, 0);
        for (int s = 0; s < 40; s++) begin
            tick(1, 1);
            repeat (39) tick(1, 0);
        end

        // randomized strobes and occasional enable drops
        en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (en && ($urandom % 300 == 0)) en = 1'b0;
            else if (!en && ($urandom % 6 == 0)) en = 1'b1;
            st = ($urandom % 5 == 0);
            tick(en, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
